sub_serial: RTL and testbench



---
 rtl/sub_serial.sv | 118 +++++++++++
 tb/tb_sub_serial.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// Bit-serial 8-bit subtractor over scrambled operands, LSB first, with a
// key-gated control FSM; a wrong key returns to IDLE and never raises done.
module sub_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] out,
  output logic       done
);

  localparam int unsigned W = 8;
  localparam int unsigned CW = 3;
  localparam logic [W-1:0] A_SCRAMBLE = 8'h8F;
  localparam logic [W-1:0] B_SCRAMBLE = 8'h23;
  localparam logic [CW-1:0] LAST_BIT = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SUB    = 3'd1,
    DONE   = 3'd2,
    DELAY0 = 3'd3,
    DELAY1 = 3'd4,
    DELAY2 = 3'd5,
    DELAY3 = 3'd6
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            borrow;

  logic            a0;
  logic            b0;
  logic            diff_bit;
  logic            borrow_next;

  // One full-subtractor slice on the current LSBs.
  always_comb begin
    a0          = a_reg[0];
    b0          = b_reg[0];
    diff_bit    = a0 ^ b0 ^ borrow;
    borrow_next = (~a0 & b0) | (~(a0 ^ b0) & borrow);
  end

  // Control FSM and datapath; the key bits of b are sampled live every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      borrow <= 1'b0;
      out    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            a_reg  <= a ^ A_SCRAMBLE;
            b_reg  <= b ^ B_SCRAMBLE;
            borrow <= 1'b0;
            count  <= '0;
            out    <= '0;
            state  <= DELAY0;
          end
        end
        DELAY0: begin
          if (en) begin
            a_reg  <= a ^ A_SCRAMBLE;
            b_reg  <= b ^ B_SCRAMBLE;
            borrow <= 1'b0;
            count  <= '0;
            out    <= '0;
          end
          state <= b[6] ? SUB : IDLE;
        end
        SUB: begin
          out    <= {diff_bit, out[W-1:1]};
          borrow <= borrow_next;
          a_reg  <= {1'b0, a_reg[W-1:1]};
          b_reg  <= {1'b0, b_reg[W-1:1]};
          count  <= count + CW'(1);
          if (count == LAST_BIT) begin
            state <= DELAY1;
          end else if (b[2]) begin
            state <= SUB;
          end else begin
            state <= IDLE;
          end
        end
        DELAY1: begin
          if (!b[5]) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        DONE: begin
          if (en) begin
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        // Decoy states, unreachable from reset.
        DELAY2: state <= b[0] ? DELAY0 : IDLE;
        DELAY3: state <= b[3] ? DELAY1 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial: stimulus pushes expected results, a
// negedge monitor pops one on every rising done.
module tb_sub_serial;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] out;
  logic       done;

  int total;
  int bad;
  logic [7:0] exp_q[$];
  logic prev_done;

  sub_serial dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .a    (a),
    .b    (b),
    .out  (out),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: number of subtract cycles the key allows, and the result
  // after that many LSB-first steps of (A' - B') mod 256.
  function automatic int n_sub(input logic [7:0] bv);
    if (!bv[6]) return 0;
    if (!bv[2]) return 1;
    return 8;
  endfunction

  function automatic logic [7:0] model_out(input logic [7:0] av, input logic [7:0] bv,
                                           input int nsub);
    int diff;
    int mask;
    diff = ((int'(av) ^ 'h8F) - (int'(bv) ^ 'h23)) & 'hFF;
    if (nsub >= 8) return 8'(diff);
    mask = (1 << nsub) - 1;
    return 8'(((diff & mask) << (8 - nsub)) & 'hFF);
  endfunction

  function automatic bit key_ok(input logic [7:0] bv);
    return bv[6] && bv[2] && !bv[5];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
    end
  endtask

  // Monitor: every rising done must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done && !prev_done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: out=0x%02h with no result pending", out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out !== e) begin
          bad++;
          $display("FAIL done_result: got 0x%02h, expected 0x%02h", out, e);
        end
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done, returning edges elapsed; a timeout is recorded as a failure.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 30) begin
      tick();
      edges++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: done=0 after %0d edges, expected 1", edges);
    end
  endtask

  // One operation started by a one-cycle en pulse.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv);
    int edges;
    a = av;
    b = bv;
    en = 1'b1;
    if (key_ok(bv)) exp_q.push_back(model_out(av, bv, 8));
    tick();
    en = 1'b0;
    if (key_ok(bv)) begin
      wait_done(edges);
      check("latency", 8'(edges), 8'd10);
      tick();
      check("done_held", {7'd0, done}, 8'd1);
      en = 1'b1;
      tick();
      en = 1'b0;
      check("done_ack", {7'd0, done}, 8'd0);
      check("out_hold_idle", out, model_out(av, bv, 8));
    end else begin
      repeat (15) tick();
      check("wrongkey_done", {7'd0, done}, 8'd0);
      check("wrongkey_out", out, model_out(av, bv, n_sub(bv)));
    end
  endtask

  initial begin
    int edges;
    logic [7:0] ra;
    logic [7:0] rb;
    total = 0;
    bad = 0;
    prev_done = 1'b0;
    rst = 1'b1;
    en = 1'b0;
    a = 8'h00;
    b = 8'h00;
    tick();
    check("reset_out", out, 8'h00);
    check("reset_done", {7'd0, done}, 8'd0);
    rst = 1'b0;

    // Directed cases.
    run_op(8'h8F, 8'h44);
    check("dir_8f_44", out, 8'h99);
    run_op(8'hFF, 8'h44);
    check("dir_ff_44", out, 8'h09);
    run_op(8'h9F, 8'h44);
    check("dir_9f_44", out, 8'hA9);
    run_op(8'h8F, 8'h04);
    run_op(8'h8F, 8'h40);
    run_op(8'h8F, 8'h64);

    // Reset while subtracting.
    a = 8'h12;
    b = 8'h44;
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out", out, 8'h00);
    check("midrst_done", {7'd0, done}, 8'd0);
    repeat (14) tick();
    check("midrst_no_done", {7'd0, done}, 8'd0);
    run_op(8'h37, 8'h46);

    // Randomized operands and keys.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 2 == 0) rb = (rb | 8'h44) & 8'hDF;
      run_op(ra, rb);
    end

    // en held high: back-to-back runs every 12 edges.
    a = 8'h5A;
    b = 8'hC6;
    en = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(model_out(8'h5A, 8'hC6, 8));
    tick();
    wait_done(edges);
    check("hold_first_latency", 8'(edges), 8'd10);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_done_drop", {7'd0, done}, 8'd0);
      check("hold_out_idle", out, model_out(8'h5A, 8'hC6, 8));
      tick();
      check("hold_reload_clear", out, 8'h00);
      wait_done(edges);
      check("hold_period", 8'(edges + 2), 8'd12);
    end
    tick();
    en = 1'b0;
    repeat (16) tick();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_results: %0d left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
